// File: rtl/axis_requant_pkg.sv
// Shared systolic-array definitions: default datapath widths and the counter-width helper.
package axis_requant_pkg;

  localparam int WY_DEF = 16;
  localparam int WO_DEF = 8;
  localparam int WS_DEF = 5;

  // Bits needed to count 0..v-1; never less than one so a counter always exists.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axis_requant_lane.sv
// One requantization lane: S1 rounds and shifts, S2 saturates (ReLU when AXIS_REQUANT_RELU_EN is defined).
module requant_lane
  import axis_requant_pkg::*;
#(
  parameter int WY = WY_DEF,
  parameter int WO = WO_DEF,
  parameter int WS = WS_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ld1,
  input  logic          ld2,
  input  logic [WY-1:0] x,
  input  logic [WS-1:0] sh,
  output logic [WO-1:0] y
);

  localparam logic signed [WY:0] MAXV = {{(WY-WO+2){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WY:0] MINV = {{(WY-WO+2){1'b1}}, {(WO-1){1'b0}}};

  logic signed [WY:0] xe;
  logic signed [WY:0] rnd;
  logic signed [WY:0] sum;
  logic signed [WY:0] y1_next;
  logic signed [WY:0] y1_reg;
  logic [WO-1:0]      y_next;
  logic [WO-1:0]      y_reg;

  assign xe = {x[WY-1], x};

  always_comb begin
    rnd     = '0;
    sum     = xe;
    y1_next = xe;
    if (int'(sh) >= WY) begin
      // Any shift this large leaves only the sign.
      y1_next = {(WY+1){x[WY-1]}};
    end else if (sh != '0) begin
      rnd     = (WY+1)'(1) << (sh - 1'b1);
      sum     = xe + rnd;
      y1_next = sum >>> sh;
    end
  end

  always_comb begin
    if (y1_reg > MAXV) begin
      y_next = {1'b0, {(WO-1){1'b1}}};
    end else if (y1_reg < MINV) begin
      y_next = {1'b1, {(WO-1){1'b0}}};
    end else begin
      y_next = y1_reg[WO-1:0];
    end
`ifdef AXIS_REQUANT_RELU_EN
    if (y_next[WO-1]) y_next = '0;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      y1_reg <= '0;
      y_reg  <= '0;
    end else begin
      if (ld1) y1_reg <= y1_next;
      if (ld2) y_reg  <= y_next;
    end
  end

  assign y = y_reg;

endmodule

// File: rtl/axis_requant.sv
// AXI-stream requantizer: R lanes of round/shift/saturate in a 2-stage pipeline with packet-length checking.
// Optional ReLU in the lanes is enabled by defining AXIS_REQUANT_RELU_EN.
module axis_requant
  import axis_requant_pkg::*;
#(
  parameter int R  = 4,
  parameter int C  = 8,
  parameter int WY = WY_DEF,
  parameter int WO = WO_DEF,
  parameter int WS = WS_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_last,
  input  logic [R*WY-1:0] s_data,
  input  logic [WS-1:0]   shift,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic [R*WO-1:0] m_data,
  output logic            err_len
);

  localparam int            CW       = clog2(C);
  localparam logic [CW-1:0] CNT_LAST = CW'(C - 1);

  logic          v1_reg;
  logic          v2_reg;
  logic          last1_reg;
  logic          last2_reg;
  logic          err_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [WS-1:0] shift_reg;
  logic [WS-1:0] cur_shift;
  logic          s_fire;
  logic          adv2;
  logic          ld2;
  logic          len_bad;

  assign adv2      = !v2_reg || m_ready;
  assign s_ready   = !v1_reg || adv2;
  assign s_fire    = s_valid && s_ready;
  assign ld2       = adv2 && v1_reg;
  // The first beat of a packet uses the live shift; later beats reuse the latched one.
  assign cur_shift = (cnt_reg == '0) ? shift : shift_reg;

  always_comb begin
    cnt_next = cnt_reg;
    len_bad  = 1'b0;
    if (s_fire) begin
      len_bad  = s_last ^ (cnt_reg == CNT_LAST);
      cnt_next = (s_last || cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      last1_reg <= 1'b0;
      last2_reg <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else begin
      if (s_ready) v1_reg <= s_valid;
      if (s_fire) last1_reg <= s_last;
      if (adv2) v2_reg <= v1_reg;
      if (ld2) last2_reg <= last1_reg;
      if (s_fire && cnt_reg == '0) shift_reg <= shift;
      if (len_bad) err_reg <= 1'b1;
      cnt_reg <= cnt_next;
    end
  end

  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_lane
      requant_lane #(
        .WY(WY),
        .WO(WO),
        .WS(WS)
      ) u_lane (
        .clk (clk),
        .rstn(rstn),
        .ld1 (s_fire),
        .ld2 (ld2),
        .x   (s_data[gi*WY +: WY]),
        .sh  (cur_shift),
        .y   (m_data[gi*WO +: WO])
      );
    end
  endgenerate

  assign m_valid = v2_reg;
  assign m_last  = last2_reg;
  assign err_len = err_reg;

endmodule

// File: tb/tb_axis_requant.sv
// Directed bench for axis_requant: behavioural scoreboard plus literal spot checks.
module tb_axis_requant;

  localparam int R  = 4;
  localparam int C  = 8;
  localparam int WY = 16;
  localparam int WO = 8;
  localparam int WS = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic            s_valid;
  logic            s_ready;
  logic            s_last;
  logic [R*WY-1:0] s_data;
  logic [WS-1:0]   shift;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;
  logic [R*WO-1:0] m_data;
  logic            err_len;

  axis_requant #(.R(R), .C(C), .WY(WY), .WO(WO), .WS(WS)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_last (s_last),
    .s_data (s_data),
    .shift  (shift),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last (m_last),
    .m_data (m_data),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [R*WO-1:0] data;
    logic            last;
  } exp_t;

  exp_t q[$];
  int   mcnt = 0;
  int   mshift = 0;
  logic exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference requantization: rounded floor division, then clamp.
  function automatic int rq(input int x, input int sh);
    int y;
    int num;
    int den;
    if (sh == 0) begin
      y = x;
    end else if (sh >= WY) begin
      y = (x < 0) ? -1 : 0;
    end else begin
      num = x + 2 ** (sh - 1);
      den = 2 ** sh;
      y = num / den;
      if ((num % den) != 0 && num < 0) y = y - 1;
    end
    if (y > 127) y = 127;
    if (y < -128) y = -128;
`ifdef AXIS_REQUANT_RELU_EN
    if (y < 0) y = 0;
`endif
    return y;
  endfunction

  function automatic logic [R*WO-1:0] model_beat(input logic [R*WY-1:0] d, input int sh);
    logic [R*WO-1:0] o;
    int x;
    int y;
    for (int i = 0; i < R; i++) begin
      x = $signed(d[i*WY +: WY]);
      y = rq(x, sh);
      o[i*WO +: WO] = y[WO-1:0];
    end
    return o;
  endfunction

  function automatic logic [R*WY-1:0] pack(input int a, input int b, input int c, input int d);
    logic [R*WY-1:0] v;
    v[0*WY +: WY] = a[WY-1:0];
    v[1*WY +: WY] = b[WY-1:0];
    v[2*WY +: WY] = c[WY-1:0];
    v[3*WY +: WY] = d[WY-1:0];
    return v;
  endfunction

  function automatic logic [R*WY-1:0] gen(input int b, input int seed);
    return pack(b * 37 - 100 + seed, 17 - b * 513 - seed, b * 4097 - 9000 + seed * 3, 300 - b * 11);
  endfunction

  // Scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    int   sh;
    if (!rstn) begin
      q.delete();
      mcnt    = 0;
      mshift  = 0;
      exp_err = 1'b0;
    end else begin
      chk("err_len", err_len, exp_err);
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_last", m_last, e.last);
        end
      end
      if (s_valid && s_ready) begin
        if (mcnt == 0) mshift = shift;
        sh = mshift;
        e.data = model_beat(s_data, sh);
        e.last = s_last;
        q.push_back(e);
        if (s_last != (mcnt == C - 1)) exp_err = 1'b1;
        mcnt = (s_last || mcnt == C - 1) ? 0 : mcnt + 1;
      end
    end
  end

  task automatic send(input logic [R*WY-1:0] d, input logic last, input int sh);
    int t;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    shift   = sh[WS-1:0];
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_pkt(input int seed, input int sh);
    for (int b = 0; b < C; b++) send(gen(b, seed), b == C - 1, sh);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    shift   = '0;
    m_ready = 1'b1;

    chk("pin_rq_291_4", rq(291, 4), 18);
    chk("pin_rq_m24_4", rq(-24, 4), -1);
    chk("pin_rq_m100_6", rq(-100, 6), -2);
    chk("pin_rq_m100_16", rq(-100, 16), -1);
    chk("pin_rq_sat", rq(32767, 0), 127);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_s_ready", s_ready, 1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Rounding, with a two-cycle latency check on the first beat.
    send(pack(291, -24, 7, 8), 1'b0, 4);
    @(posedge clk);
    #1;
    chk("round_valid", m_valid, 1);
    chk("round_data", m_data, 32'h0100FF12);
    for (int b = 1; b < C; b++) send(gen(b, 1), b == C - 1, 9);
    drain();

    // Saturation.
    send(pack(32767, -300, 127, -128), 1'b0, 0);
    @(posedge clk);
    #1;
`ifdef AXIS_REQUANT_RELU_EN
    chk("sat_data", m_data, 32'h007F007F);
`else
    chk("sat_data", m_data, 32'h807F807F);
`endif
    for (int b = 1; b < C; b++) send(gen(b, 2) * 8, b == C - 1, 0);
    drain();

    // Shift of exactly WY and one just below.
    send_pkt(3, 16);
    send_pkt(4, 15);
    drain();

    // Backpressure: two beats fill the pipe, then input stalls.
    m_ready = 1'b0;
    send(gen(0, 5), 1'b0, 3);
    send(gen(1, 5), 1'b0, 3);
    s_valid = 1'b1;
    s_data  = gen(2, 5);
    @(negedge clk);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_m_valid", m_valid, 1);
    fork
      begin
        for (int b = 2; b < C; b++) send(gen(b, 5), b == C - 1, 3);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // Shift latched on beat 0; mid-packet change only affects the next packet.
    for (int b = 0; b < C; b++) send(pack(100, -100, 1000, 3 + b), b == C - 1, (b < 3) ? 2 : 6);
    send_pkt(6, 6);
    drain();

    // Random downstream stalls on a full packet.
    fork
      send_pkt(7, 5);
      begin
        repeat (30) begin
          @(posedge clk);
          #1;
          m_ready = $urandom_range(0, 1) == 1;
        end
        m_ready = 1'b1;
      end
    join
    drain();

    // Short packet raises a sticky length error.
    for (int b = 0; b < 6; b++) send(gen(b, 8), b == 5, 1);
    chk("len_err_set", err_len, 1);
    send_pkt(9, 2);
    drain();
    chk("len_err_sticky", err_len, 1);

    // Reset in the middle of a packet.
    for (int b = 0; b < 4; b++) send(gen(b, 10), 1'b0, 4);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_err_len", err_len, 0);
    rstn = 1'b1;
    send_pkt(11, 4);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_err", err_len, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
